// File: rtl/aibnd_dly_pkg.sv
// Shared types and helpers for the delay-line code controller.
// Holds parameter defaults, FSM states and the thermometer encoder.
package aibnd_dly_pkg;

    localparam int NSTAGE_DEF = 6;
    localparam int SETTLE_DEF = 4;
    localparam int CNT_W      = 8;
    localparam int THERM_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        SETTLE,
        RB_SHIFT
    } state_t;

    // Codes above the stage count saturate to all ones.
    function automatic logic [THERM_W-1:0] therm(
        input logic [2:0] code,
        input int         nstage
    );
        logic [THERM_W-1:0] t;
        int                 n;
        n = {29'd0, code};
        if (n > nstage) n = nstage;
        t = '0;
        for (int i = 0; i < THERM_W; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/aibnd_dly_settle_cnt.sv
// Loadable down-counter with zero flag.
// Times both the settle window and the scan shift.
module aibnd_dly_settle_cnt
    import aibnd_dly_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         ck,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/aibnd_dly_code_ctrl.sv
// Delay-line code controller: loads a thermometer code, strobes it,
// waits for settle and can scan-verify the chain contents.
module aibnd_dly_code_ctrl
    import aibnd_dly_pkg::*;
#(
    parameter int NSTAGE     = NSTAGE_DEF,
    parameter int SETTLE_CYC = SETTLE_DEF
) (
    input  logic              ck,
    input  logic              nrst,
    input  logic              req_vld,
    input  logic [2:0]        req_code,
    output logic              req_rdy,
    input  logic              rb_req,
    output logic [NSTAGE-1:0] bk,
    output logic              code_valid,
    output logic              se_n,
    output logic              si,
    input  logic              so,
    output logic              busy,
    output logic              done,
    output logic              rb_err
);

    state_t             state_q;
    state_t             state_d;
    logic [NSTAGE-1:0]  bk_d;
    logic               cv_d;
    logic               se_n_d;
    logic               si_d;
    logic               done_d;
    logic               rb_err_d;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic [THERM_W-1:0] th_full;

    assign th_full = therm(req_code, NSTAGE);

    generate
        if (NSTAGE < THERM_W) begin : g_th_spare
            logic unused_th;
            assign unused_th = ^th_full[THERM_W-1:NSTAGE];
        end
    endgenerate

    function automatic logic pick(
        input logic [NSTAGE-1:0] v,
        input int                idx
    );
        logic b;
        b = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i == idx) b = v[i];
        end
        return b;
    endfunction

    aibnd_dly_settle_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .ck       (ck),
        .nrst     (nrst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan runs MSB first so the shifted-in bits land back in place.
    always_comb begin
        state_d  = state_q;
        bk_d     = bk;
        cv_d     = 1'b0;
        se_n_d   = 1'b1;
        si_d     = 1'b0;
        done_d   = 1'b0;
        rb_err_d = rb_err;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_d = STROBE;
                    bk_d    = th_full[NSTAGE-1:0];
                    cv_d    = 1'b1;
                end else if (rb_req) begin
                    state_d  = RB_SHIFT;
                    se_n_d   = 1'b0;
                    si_d     = bk[NSTAGE-1];
                    rb_err_d = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(NSTAGE - 1);
                end
            end
            STROBE: begin
                state_d  = SETTLE;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(SETTLE_CYC - 1);
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RB_SHIFT: begin
                if (so != si) rb_err_d = 1'b1;
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    se_n_d  = 1'b0;
                    si_d    = pick(bk, int'(cnt) - 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            bk         <= '0;
            code_valid <= 1'b0;
            se_n       <= 1'b1;
            si         <= 1'b0;
            done       <= 1'b0;
            rb_err     <= 1'b0;
        end else begin
            bk         <= bk_d;
            code_valid <= cv_d;
            se_n       <= se_n_d;
            si         <= si_d;
            done       <= done_d;
            rb_err     <= rb_err_d;
        end
    end

    assign req_rdy = (state_q == IDLE);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_aibnd_dly_code_ctrl.sv
// Bench for aibnd_dly_code_ctrl: scripted output model plus
// a 6-stage scan-chain delay-line model with an optional stuck stage.
module tb_aibnd_dly_code_ctrl;

    localparam int N  = 6;
    localparam int SC = 4;

    logic         ck = 1'b0;
    logic         nrst = 1'b0;
    logic         req_vld = 1'b0;
    logic [2:0]   req_code = 3'd0;
    logic         req_rdy;
    logic         rb_req = 1'b0;
    logic [N-1:0] bk;
    logic         code_valid;
    logic         se_n;
    logic         si;
    logic         so;
    logic         busy;
    logic         done;
    logic         rb_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    aibnd_dly_code_ctrl #(
        .NSTAGE     (N),
        .SETTLE_CYC (SC)
    ) dut (
        .ck         (ck),
        .nrst       (nrst),
        .req_vld    (req_vld),
        .req_code   (req_code),
        .req_rdy    (req_rdy),
        .rb_req     (rb_req),
        .bk         (bk),
        .code_valid (code_valid),
        .se_n       (se_n),
        .si         (si),
        .so         (so),
        .busy       (busy),
        .done       (done),
        .rb_err     (rb_err)
    );

    always #5 ck = ~ck;

    // Delay-line scan chain; stage 2 may be stuck at 0.
    logic [N-1:0] chain = '0;
    bit           stuck = 1'b0;
    assign so = chain[N-1];

    always @(posedge ck) begin
        logic [N-1:0] nx;
        nx = chain;
        if (code_valid) nx = bk;
        else if (!se_n) nx = {chain[N-2:0], si};
        if (stuck) nx[2] = 1'b0;
        chain <= nx;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: each accepted operation queues its per-cycle output script.
    typedef struct packed {
        logic busy;
        logic cv;
        logic se_n;
        logic si;
        logic done;
        logic shift;
    } rec_t;

    rec_t         q[$];
    rec_t         cur = '{0, 0, 1, 0, 0, 0};
    logic [N-1:0] mbk = '0;
    logic         merr = 1'b0;

    function automatic rec_t mk(input logic b, input logic c,
                                input logic s, input logic d,
                                input logic dn, input logic sh);
        rec_t r;
        r = '{b, c, s, d, dn, sh};
        return r;
    endfunction

    always @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            q.delete();
            cur  = mk(0, 0, 1, 0, 0, 0);
            mbk  = '0;
            merr = 1'b0;
        end else begin
            if (cur.shift && (so !== cur.si)) merr = 1'b1;
            if (!cur.busy && req_vld) begin
                int n;
                n = req_code;
                if (n > N) n = N;
                mbk = N'((1 << n) - 1);
                q.push_back(mk(1, 1, 1, 0, 0, 0));
                repeat (SC) q.push_back(mk(1, 0, 1, 0, 0, 0));
                q.push_back(mk(0, 0, 1, 0, 1, 0));
            end else if (!cur.busy && rb_req) begin
                merr = 1'b0;
                for (int k = 0; k < N; k++)
                    q.push_back(mk(1, 0, 0, mbk[N-1-k], 0, 1));
                q.push_back(mk(0, 0, 1, 0, 1, 0));
            end
            if (q.size() != 0) cur = q.pop_front();
            else cur = mk(0, 0, 1, 0, 0, 0);
        end
    end

    always @(negedge ck) begin
        if (cmp_en) begin
            chk("bk", bk, mbk);
            chk("code_valid", code_valid, cur.cv);
            chk("se_n", se_n, cur.se_n);
            chk("si", si, cur.si);
            chk("busy", busy, cur.busy);
            chk("req_rdy", req_rdy, !cur.busy);
            chk("done", done, cur.done);
            chk("rb_err", rb_err, merr);
        end
    end

    task automatic step();
        @(negedge ck);
        #2;
    endtask

    task automatic wait_done(input int exp_lat, input string nm);
        int lat;
        int cvn;
        lat = 0;
        cvn = 0;
        do begin
            step();
            lat++;
            if (code_valid) cvn++;
        end while (!done && lat < 20);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_cv_extra"}, cvn, 0);
    endtask

    task automatic load_code(input logic [2:0] code,
                             input logic [N-1:0] exp_bk,
                             input string nm);
        req_vld  = 1'b1;
        req_code = code;
        step();
        chk({nm, "_cv"}, code_valid, 1'b1);
        chk({nm, "_bk"}, bk, exp_bk);
        req_vld = 1'b0;
        wait_done(SC + 1, nm);
    endtask

    task automatic readback(input logic [N-1:0] exp_seq,
                            input logic exp_err,
                            input logic [N-1:0] exp_chain,
                            input string nm);
        logic [N-1:0] seq;
        int           sen;
        int           lat;
        rb_req = 1'b1;
        step();
        rb_req = 1'b0;
        chk({nm, "_err_clr"}, rb_err, 1'b0);
        seq = '0;
        sen = 0;
        lat = 0;
        while (!done && lat < 20) begin
            if (!se_n) begin
                sen++;
                seq = {seq[N-2:0], si};
            end
            step();
            lat++;
        end
        chk({nm, "_sen_cnt"}, sen, N);
        chk({nm, "_si_seq"}, seq, exp_seq);
        chk({nm, "_err"}, rb_err, exp_err);
        chk({nm, "_chain"}, chain, exp_chain);
    endtask

    initial begin
        cmp_en = 1'b1;
        repeat (3) step();
        chk("rst_bk", bk, 6'b000000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", req_rdy, 1'b1);
        chk("rst_se_n", se_n, 1'b1);
        chk("rst_done", done, 1'b0);
        nrst = 1'b1;
        step();

        load_code(3'd3, 6'b000111, "code3");
        load_code(3'd7, 6'b111111, "code7");
        chk("code7_noX", $isunknown(bk), 1'b0);

        load_code(3'd3, 6'b000111, "reload3");
        readback(6'b000111, 1'b0, 6'b000111, "rb_ok");

        stuck = 1'b1;
        step();
        readback(6'b000111, 1'b1, 6'b000011, "rb_stuck");
        repeat (5) step();
        chk("rb_err_sticky", rb_err, 1'b1);
        stuck = 1'b0;
        readback(6'b000111, 1'b1, 6'b000111, "rb_again");

        req_vld  = 1'b1;
        rb_req   = 1'b1;
        req_code = 3'd5;
        step();
        chk("both_cv", code_valid, 1'b1);
        chk("both_bk", bk, 6'b011111);
        chk("both_se_n", se_n, 1'b1);
        req_vld = 1'b0;
        wait_done(SC + 1, "both");
        chk("both_se_n_done", se_n, 1'b1);
        step();
        chk("both_rb_start", se_n, 1'b0);
        rb_req = 1'b0;
        wait_done(N, "both_rb");
        chk("both_rb_err", rb_err, 1'b0);

        req_vld  = 1'b1;
        req_code = 3'd2;
        step();
        req_vld = 1'b0;
        step();
        step();
        nrst = 1'b0;
        #1;
        chk("abort_bk", bk, 6'b000000);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        step();
        chk("abort_done2", done, 1'b0);
        nrst     = 1'b1;
        req_vld  = 1'b1;
        req_code = 3'd4;
        step();
        chk("post_rst_cv", code_valid, 1'b1);
        chk("post_rst_bk", bk, 6'b001111);
        chk("post_rst_done", done, 1'b0);
        req_vld = 1'b0;
        wait_done(SC + 1, "post_rst");

        for (int c = 0; c < 3000; c++) begin
            step();
            req_vld  = ($urandom_range(0, 3) == 0);
            req_code = 3'($urandom_range(0, 7));
            rb_req   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) stuck = ~stuck;
            nrst = ($urandom_range(0, 399) != 0);
        end
        nrst    = 1'b1;
        req_vld = 1'b0;
        rb_req  = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aibnd_dly_code_ctrl.md
AIBND_DLY_CODE_CTRL -- requirements
Module: aibnd_dly_code_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 6: number of delay-line stages driven.
REQ-002 SHALL have parameter SETTLE_CYC, default 4, legal range 1..255: settle cycles after each strobe.
REQ-003 SHALL have port ck, input, 1 bit: the single clock.
REQ-004 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_vld, input, 1 bit: new delay-code request.
REQ-006 SHALL have port req_code, input, 3 bits: binary stage count, 0..NSTAGE.
REQ-007 SHALL have port req_rdy, output, 1 bit: controller accepts a request.
REQ-008 SHALL have port rb_req, input, 1 bit: scan readback/verify request.
REQ-009 SHALL have port bk, output, NSTAGE bits: thermometer code to the delay-line stages.
REQ-010 SHALL have port code_valid, output, 1 bit: code-load strobe to the delay line.
REQ-011 SHALL have port se_n, output, 1 bit: delay-line scan enable, active-low.
REQ-012 SHALL have port si, output, 1 bit: scan data into delay-line stage 0.
REQ-013 SHALL have port so, input, 1 bit: scan data out of the last delay-line stage.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port rb_err, output, 1 bit: sticky readback mismatch flag.

Function
REQ-017 SHALL implement FSM states IDLE, STROBE, SETTLE, RB_SHIFT; req_rdy = (state==IDLE).
REQ-018 SHALL accept a request on a ck edge where req_vld=1 and state is IDLE; at that edge, bk SHALL load therm(req_code), defined as bit i = 1 iff i < req_code.
REQ-019 SHALL saturate req_code > NSTAGE to NSTAGE, so all bk bits are 1.
REQ-020 SHALL hold bk constant except at an accept edge.
REQ-021 SHALL go to STROBE after accept; code_valid=1 for exactly the one STROBE cycle immediately following the accept edge.
REQ-022 SHALL stay in SETTLE for exactly SETTLE_CYC cycles (down-counter), then return to IDLE.
REQ-023 SHALL assert done for the first IDLE cycle after SETTLE, i.e. 1+SETTLE_CYC cycles after the code_valid cycle.
REQ-024 SHALL leave IDLE on rb_req=1 with req_vld=0 and enter RB_SHIFT for exactly NSTAGE cycles with se_n=0; se_n=1 in all other states.
REQ-025 SHALL, in RB_SHIFT cycle k (k = 0..NSTAGE-1), drive si = bk[NSTAGE-1-k] and sample so at the closing edge against bk[NSTAGE-1-k]; this shift order restores the chain contents.
REQ-026 SHALL set rb_err on any mismatch; rb_err SHALL clear only at the edge where a new readback starts.
REQ-027 SHALL return to IDLE after RB_SHIFT and pulse done for one cycle.
REQ-028 SHALL give req_vld priority when req_vld and rb_req are both high in IDLE; rb_req SHALL remain pending while held.
REQ-029 SHALL ignore req_vld and rb_req while busy; requesters hold the request until req_rdy.

Reset
REQ-030 SHALL, while nrst=0, asynchronously force: state=IDLE, bk=0, code_valid=0, se_n=1, si=0, busy=0, done=0, rb_err=0, counters=0.
REQ-031 SHALL abort any operation on reset mid-STROBE, SETTLE or RB_SHIFT; no done pulse follows reset release.
REQ-032 SHALL reach IDLE with req_rdy=1 on the first ck edge after nrst deasserts.

Structure
REQ-033 SHALL use shared package aibnd_dly_pkg holding the NSTAGE default, SETTLE_CYC default, FSM state typedef and the therm() saturating encode function.
REQ-034 SHALL register every output; no combinational path from inputs to outputs.
REQ-035 SHALL have at most one sub-module, aibnd_dly_settle_cnt (loadable down-counter with zero flag), shared by SETTLE and RB_SHIFT.

Verification
REQ-036 Reset, then req_vld=1 with req_code=3 -> bk=6'b000111; code_valid high 1 cycle; done exactly 5 cycles after the code_valid cycle.
REQ-037 req_code=7 -> bk=6'b111111, no X, same timing as REQ-036.
REQ-038 bk=6'b000111, rb_req=1, behavioural 6-stage scan-chain model -> se_n low 6 cycles; si sequence 0,0,0,1,1,1; rb_err=0; chain contents unchanged.
REQ-039 Same as REQ-038 with model stage 2 stuck at 0 -> rb_err=1 after RB_SHIFT, held until the next rb_req.
REQ-040 req_vld and rb_req high together in IDLE -> code update first; readback starts the cycle after its done pulse.
REQ-041 nrst low during cycle 2 of SETTLE -> bk=0, busy=0, no done pulse; a new request is accepted on the first edge after release.
